// File: rtl/slave_memory_burst_if.sv
// Unidirectional memory-slave bus: command/address phase plus per-beat data and handshake.
interface slave_memory_burst_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  En;
   logic [ADDR_WIDTH-1:0] Addr;
   logic [8:0]            Control;
   logic [DATA_WIDTH-1:0] DataIn;
   logic [DATA_WIDTH-1:0] DataOut;
   logic                  Ready;
   logic                  Error;

   modport master (
      output En, Addr, Control, DataIn,
      input  DataOut, Ready, Error
   );

   modport slave (
      input  En, Addr, Control, DataIn,
      output DataOut, Ready, Error
   );
endinterface

// File: rtl/slave_memory_burst.sv
// Burst-capable memory slave: byte-addressable word array with wait states, INCR/WRAP bursts,
// alignment errors and command acceptance on the last beat of the previous command.
module slave_memory_burst #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DEPTH_LOG2  = 8,
   parameter int unsigned WAIT_STATES = 1
) (
   input logic                 Clk,
   input logic                 Rst,
   slave_memory_burst_if.slave bus
);
   localparam int unsigned NumLanes = DATA_WIDTH / 8;
   localparam int unsigned LaneBits = $clog2(NumLanes);
   localparam int unsigned Depth    = 1 << DEPTH_LOG2;
   localparam logic [1:0]  MaxSize  = (DATA_WIDTH == 64) ? 2'd3 : 2'd2;

   typedef enum logic [1:0] {StIdle, StWait, StBeat} stateT;

   stateT                 stateQ, stateD;
   logic [ADDR_WIDTH-1:0] addrQ, addrD;
   logic                  writeQ, writeD;
   logic [1:0]            sizeQ, sizeD;
   logic                  wrapQ, wrapD;
   logic [2:0]            lastIdxQ, lastIdxD;
   logic [2:0]            beatQ, beatD;
   logic [2:0]            waitQ, waitD;
   logic                  errQ, errD;

   logic [DATA_WIDTH-1:0] mem [Depth];

   logic [1:0]            cmdSize;
   logic [2:0]            cmdLastIdx;
   logic                  cmdWrap;
   logic [2:0]            cmdLowMask;
   logic                  cmdErr;
   logic                  lastBeat;
   logic                  accept;
   stateT                 startState;
   logic [ADDR_WIDTH-1:0] incAddr, blockMask, nextAddr;
   logic [LaneBits-1:0]   laneOff;
   logic [DEPTH_LOG2-1:0] wordIdx;
   logic [NumLanes-1:0]   byteEn;
   logic [DATA_WIDTH-1:0] wrData, rdShift, rdData;
   logic                  unusedCtrl;

   assign unusedCtrl = ^bus.Control[8:6];
   assign cmdSize    = bus.Control[2:1];

   // Command decode on the incoming address phase
   always_comb begin
      cmdLastIdx = 3'd0;
      cmdWrap    = 1'b0;
      unique case (bus.Control[5:3])
         3'b001:  cmdLastIdx = 3'd3;
         3'b010:  begin cmdLastIdx = 3'd3; cmdWrap = 1'b1; end
         3'b011:  cmdLastIdx = 3'd7;
         3'b100:  begin cmdLastIdx = 3'd7; cmdWrap = 1'b1; end
         default: cmdLastIdx = 3'd0;
      endcase
      unique case (cmdSize)
         2'd0:    cmdLowMask = 3'b000;
         2'd1:    cmdLowMask = 3'b001;
         2'd2:    cmdLowMask = 3'b011;
         default: cmdLowMask = 3'b111;
      endcase
      cmdErr = ((bus.Addr[2:0] & cmdLowMask) != 3'b000) || (cmdSize > MaxSize);
   end

   // An error beat always terminates the command
   assign lastBeat   = (stateQ == StBeat) && (errQ || (beatQ == lastIdxQ));
   assign accept     = bus.En && (stateQ == StIdle || lastBeat);
   assign startState = (WAIT_STATES == 0) ? StBeat : StWait;

   // Wrap keeps the upper block bits and lets only the offset inside the block advance
   assign incAddr   = addrQ + (ADDR_WIDTH'(1) << sizeQ);
   assign blockMask = ((ADDR_WIDTH'(lastIdxQ) + ADDR_WIDTH'(1)) << sizeQ) - ADDR_WIDTH'(1);
   assign nextAddr  = wrapQ ? ((addrQ & ~blockMask) | (incAddr & blockMask)) : incAddr;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         stateQ <= StIdle;
      end else begin
         stateQ <= stateD;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         addrQ    <= '0;
         writeQ   <= 1'b0;
         sizeQ    <= 2'd0;
         wrapQ    <= 1'b0;
         lastIdxQ <= 3'd0;
         beatQ    <= 3'd0;
         waitQ    <= 3'd0;
         errQ     <= 1'b0;
      end else begin
         addrQ    <= addrD;
         writeQ   <= writeD;
         sizeQ    <= sizeD;
         wrapQ    <= wrapD;
         lastIdxQ <= lastIdxD;
         beatQ    <= beatD;
         waitQ    <= waitD;
         errQ     <= errD;
      end
   end

   always_comb begin
      stateD   = stateQ;
      addrD    = addrQ;
      writeD   = writeQ;
      sizeD    = sizeQ;
      wrapD    = wrapQ;
      lastIdxD = lastIdxQ;
      beatD    = beatQ;
      waitD    = waitQ;
      errD     = errQ;
      unique case (stateQ)
         StIdle: if (accept) stateD = startState;
         StWait: begin
            waitD = waitQ + 3'd1;
            if (waitQ == 3'(WAIT_STATES - 1)) stateD = StBeat;
         end
         StBeat: begin
            if (lastBeat) begin
               stateD = accept ? startState : StIdle;
            end else begin
               beatD = beatQ + 3'd1;
               addrD = nextAddr;
            end
         end
         default: stateD = StIdle;
      endcase
      if (accept) begin
         addrD    = bus.Addr;
         writeD   = bus.Control[0];
         sizeD    = cmdSize;
         wrapD    = cmdWrap;
         lastIdxD = cmdLastIdx;
         errD     = cmdErr;
         beatD    = 3'd0;
         waitD    = 3'd0;
      end
   end

   assign laneOff = addrQ[LaneBits-1:0];
   assign wordIdx = addrQ[LaneBits +: DEPTH_LOG2];
   assign wrData  = bus.DataIn << {laneOff, 3'b000};
   assign rdShift = mem[wordIdx] >> {laneOff, 3'b000};

   always_comb begin
      for (int b = 0; b < NumLanes; b++) begin
         byteEn[b]       = (b >= int'(laneOff)) && (b < int'(laneOff) + (1 << sizeQ));
         rdData[8*b +: 8] = (b < (1 << sizeQ)) ? rdShift[8*b +: 8] : 8'h00;
      end
   end

   always_ff @(posedge Clk) begin
      if (stateQ == StBeat && writeQ && !errQ) begin
         for (int b = 0; b < NumLanes; b++) begin
            if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
         end
      end
   end

   always_comb begin
      bus.Ready   = (stateQ != StWait);
      bus.Error   = (stateQ == StBeat) && errQ;
      bus.DataOut = '0;
      if (stateQ == StBeat && !errQ && !writeQ) bus.DataOut = rdData;
   end
endmodule
